// File: rtl/jk_universal_shift_reg.sv
// jk_universal_shift_reg
//
// Purpose:
//   A universal shift register of WIDTH bits. Every bit is stored in a JK
//   stage. Under manual control it can hold, shift right, shift left or
//   parallel-load. It can also run a burst of exactly WIDTH shifts in one
//   direction, controlled by a small IDLE/BUSY/DONE state machine.
//
// Ports:
//   clk     in   1      single clock; all state changes on its rising edge
//   rst_n   in   1      asynchronous active-low reset
//   mode    in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r   in   1      serial in, enters q[WIDTH-1] on a right shift
//   sin_l   in   1      serial in, enters q[0] on a left shift
//   pin     in   WIDTH  parallel load data
//   start   in   1      burst request, level-sampled every cycle
//   q       out  WIDTH  register contents
//   sout_l  out  1      q[WIDTH-1]
//   sout_r  out  1      q[0]
//   busy    out  1      high while a burst is shifting
//   done    out  1      one-cycle pulse after a burst completes

module jk_universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               dir_left;
  logic               dir_next;
  logic [WIDTH-1:0]   next_val;
  logic [WIDTH-1:0]   shift_r;
  logic [WIDTH-1:0]   shift_l;
  logic [WIDTH-1:0]   j;
  logic [WIDTH-1:0]   k;

  assign shift_r = {sin_r, q[WIDTH-1:1]};
  assign shift_l = {q[WIDTH-2:0], sin_l};

  // Each JK stage is driven so that it lands on the desired next value:
  // J is the wanted value and K is its inverse. A '1' therefore sets the
  // stage and a '0' resets it.
  assign j = next_val;
  assign k = ~next_val;

  // Next-state logic. A burst request is taken only with a shift mode.
  // The accepting cycle itself does not shift; the WIDTH shifts follow in
  // BUSY and use the serial inputs as they are at each of those edges.
  always_comb begin
    next_state = state;
    next_val   = q;
    cnt_next   = cnt;
    dir_next   = dir_left;
    case (state)
      IDLE: begin
        if (start && (mode == MODE_RIGHT || mode == MODE_LEFT)) begin
          dir_next   = (mode == MODE_LEFT);
          cnt_next   = CNT_W'(WIDTH);
          next_state = BUSY;
        end else begin
          case (mode)
            MODE_HOLD:  next_val = q;
            MODE_RIGHT: next_val = shift_r;
            MODE_LEFT:  next_val = shift_l;
            default:    next_val = pin;
          endcase
        end
      end
      BUSY: begin
        next_val = dir_left ? shift_l : shift_r;
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Register bank. q uses the JK characteristic equation Q+ = J~Q | ~KQ.
  // Reset clears everything at once, so a reset during BUSY or DONE drops
  // the burst and no done pulse follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      state    <= IDLE;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else begin
      q        <= (j & ~q) | (~k & q);
      state    <= next_state;
      cnt      <= cnt_next;
      dir_left <= dir_next;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_jk_universal_shift_reg.sv
// tb_jk_universal_shift_reg
//
// Purpose:
//   Directed test of jk_universal_shift_reg at WIDTH=8. Expected values are
//   worked out by hand from the intended behaviour.
//
// Ports: none (top-level bench).

module tb_jk_universal_shift_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  int checkCount;
  int passCount;

  jk_universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pin    (pin),
    .start  (start),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock. Rising edges fall at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every functional input at once.
  task automatic applyStimulus(input logic [1:0] m, input logic sr,
                               input logic sl, input logic [7:0] p,
                               input logic st);
    mode  = m;
    sin_r = sr;
    sin_l = sl;
    pin   = p;
    start = st;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
  endtask

  // One clock: through the rising edge, then to the falling edge, where
  // outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] soutSeq;
    int         busyCycles;

    checkCount = 0;
    passCount  = 0;
    soutSeq    = 8'b0011_1100;
    rst_n      = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of a cycle clears outputs at once.
    applyStimulus(2'b11, 1'b0, 1'b0, 8'hFF, 1'b0);
    tick();
    checkOutput("preload_ff", q, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_q", q, 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_done", 8'(done), 8'h00);
    checkOutput("rst_sout_l", 8'(sout_l), 8'h00);
    checkOutput("rst_sout_r", 8'(sout_r), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and hold.
    applyStimulus(2'b11, 1'b0, 1'b0, 8'hA5, 1'b0);
    tick();
    checkOutput("load_a5", q, 8'hA5);
    applyStimulus(2'b00, 1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_a5", q, 8'hA5);
    end

    // Manual shifts.
    applyStimulus(2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("shift_r_d2", q, 8'hD2);
    applyStimulus(2'b10, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("shift_l_a4", q, 8'hA4);
    checkOutput("sout_l_a4", 8'(sout_l), 8'h01);
    checkOutput("sout_r_a4", 8'(sout_r), 8'h00);

    // Left burst from 0x3C, with mode flipped to right once BUSY is entered
    // and start held high to show both are ignored.
    applyStimulus(2'b11, 1'b0, 1'b0, 8'h3C, 1'b0);
    tick();
    checkOutput("load_3c", q, 8'h3C);
    applyStimulus(2'b10, 1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    checkOutput("accept_busy", 8'(busy), 8'h01);
    checkOutput("accept_noshift", q, 8'h3C);
    applyStimulus(2'b01, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("burst_busy", 8'(busy), 8'h01);
      checkOutput("burst_sout_l", 8'(sout_l), 8'(soutSeq[7-i]));
      tick();
    end
    checkOutput("burst_end_q", q, 8'hFF);
    checkOutput("burst_done", 8'(done), 8'h01);
    checkOutput("burst_done_busy", 8'(busy), 8'h00);

    // Start still high with mode=01: the IDLE cycle after DONE accepts a
    // right burst; sin_r=0 drains the register to zero.
    applyStimulus(2'b01, 1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    checkOutput("idle_gap_done", 8'(done), 8'h00);
    checkOutput("idle_gap_busy", 8'(busy), 8'h00);
    checkOutput("idle_gap_q", q, 8'hFF);
    tick();
    busyCycles = 0;
    while (busy === 1'b1 && busyCycles < 20) begin
      busyCycles++;
      tick();
    end
    checkOutput("b2b_busy_len", 8'(busyCycles), 8'd8);
    checkOutput("b2b_done", 8'(done), 8'h01);
    checkOutput("b2b_q", q, 8'h00);
    applyStimulus(2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("b2b_after_done", 8'(done), 8'h00);

    // Abort a burst with reset after its third shift.
    applyStimulus(2'b11, 1'b0, 1'b0, 8'h3C, 1'b0);
    tick();
    applyStimulus(2'b10, 1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("abort_pre_q", q, 8'hE7);
    checkOutput("abort_pre_busy", 8'(busy), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_q", q, 8'h00);
    checkOutput("abort_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("abort_no_done", 8'(done), 8'h00);
      checkOutput("abort_no_busy", 8'(busy), 8'h00);
    end
    applyStimulus(2'b11, 1'b0, 1'b0, 8'h5A, 1'b0);
    tick();
    checkOutput("abort_reload", q, 8'h5A);

    // start with a non-shift mode is not a burst request.
    applyStimulus(2'b00, 1'b1, 1'b1, 8'hFF, 1'b1);
    tick();
    checkOutput("start_hold_busy", 8'(busy), 8'h00);
    checkOutput("start_hold_q", q, 8'h5A);
    applyStimulus(2'b11, 1'b1, 1'b1, 8'hC3, 1'b1);
    tick();
    checkOutput("start_load_q", q, 8'hC3);
    checkOutput("start_load_busy", 8'(busy), 8'h00);
    tick();
    checkOutput("start_load_busy2", 8'(busy), 8'h00);
    checkOutput("start_load_done2", 8'(done), 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
